// File: rtl/hart_issue_sched_pkg.sv
// Shared widths, types and state encodings for the per-cycle hart fetch scheduler.
// Mask width and id width are tied: HART_ID_W must be log2(HART_NUM).
package hart_issue_sched_pkg;

    localparam int HART_NUM     = 4;
    localparam int HART_ID_W    = 2;
    localparam int HART_STATE_B = HART_NUM - 1;
    localparam int HART_ID_B    = HART_ID_W - 1;
    localparam int PRIM_BURST   = 3;
    localparam int BURST_W      = 2;

    typedef logic [HART_STATE_B:0] hart_state_t;
    typedef logic [HART_ID_B:0]    hart_id_t;
    typedef logic [BURST_W-1:0]    burst_cnt_t;

    localparam burst_cnt_t BURST_MAX = burst_cnt_t'(PRIM_BURST);

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_PRIM  = 2'd1,
        SCHED_SHARE = 2'd2
    } sched_state_e;

    function automatic hart_id_t onehot_to_id(input hart_state_t oh);
        hart_id_t id;
        id = '0;
        for (int i = 0; i < HART_NUM; i++) begin
            if (oh[i]) begin
                id = hart_id_t'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/hart_issue_sched_if.sv
// Hart-state inputs, IF-stage stall and issue outputs of the fetch scheduler.
// master is the scheduler; slave is the hart state unit / IF stage side.
interface hart_issue_sched_if
    import hart_issue_sched_pkg::*;
    ();

    hart_state_t acti_hstate;
    hart_state_t prim_hstate;
    logic        if_stall;
    logic        issue_valid;
    hart_id_t    issue_hid;
    hart_state_t issue_hstate;
    logic        hart_switch;
    logic [1:0]  sched_state;

    modport master (
        input  acti_hstate, prim_hstate, if_stall,
        output issue_valid, issue_hid, issue_hstate, hart_switch, sched_state
    );

    modport slave (
        output acti_hstate, prim_hstate, if_stall,
        input  issue_valid, issue_hid, issue_hstate, hart_switch, sched_state
    );

endinterface

// File: rtl/hart_issue_sched_rr_hart_pick.sv
// Combinational round-robin pick: first set bit of mask at ids ptr+1, ptr+2, ...
// wrapping back to ptr itself.
module rr_hart_pick
    import hart_issue_sched_pkg::*;
(
    input  hart_state_t mask,
    input  hart_id_t    ptr,
    output logic        found,
    output hart_id_t    hid,
    output hart_state_t hstate
);

    // rot[k] is the mask bit of the hart k+1 positions after ptr
    hart_state_t rot;

    for (genvar gi = 0; gi < HART_NUM; gi++) begin : g_rot
        localparam hart_id_t OFS = hart_id_t'(gi + 1);
        assign rot[gi] = mask[ptr + OFS];
    end

    always_comb begin
        found  = 1'b0;
        hid    = ptr;
        for (int i = HART_NUM - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                hid   = ptr + hart_id_t'(i + 1);
            end
        end
        hstate = found ? (hart_state_t'(1) << hid) : '0;
    end

endmodule

// File: rtl/hart_issue_sched.sv
// Fetch scheduler: primary hart first, one forced share slot after PRIM_BURST
// back-to-back primary issues, round-robin among the rest; holds on IF stall.
module hart_issue_sched
    import hart_issue_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    hart_issue_sched_if.master    bus
);

    hart_state_t  prim_act;
    hart_state_t  others;
    hart_state_t  pick_mask;
    logic         prim_ok;
    logic         pick_found;
    hart_id_t     pick_hid;
    hart_state_t  pick_hstate;

    logic         sel_share;
    hart_id_t     sel_hid;
    hart_state_t  sel_hstate;

    sched_state_e state_reg;
    logic         issue_valid_reg;
    hart_id_t     issue_hid_reg;
    hart_state_t  issue_hstate_reg;
    logic         hart_switch_reg;
    hart_id_t     rr_ptr_reg;
    burst_cnt_t   burst_cnt_reg;
    logic         had_issue_reg;

    assign prim_act  = bus.prim_hstate & bus.acti_hstate;
    assign prim_ok   = |prim_act;
    assign others    = bus.acti_hstate & ~bus.prim_hstate;
    // With a live primary the RR picker only ever serves the share slot
    assign pick_mask = prim_ok ? others : bus.acti_hstate;

    rr_hart_pick u_pick (
        .mask   (pick_mask),
        .ptr    (rr_ptr_reg),
        .found  (pick_found),
        .hid    (pick_hid),
        .hstate (pick_hstate)
    );

    always_comb begin
        sel_share  = !prim_ok || (pick_found && (burst_cnt_reg == BURST_MAX));
        sel_hid    = sel_share ? pick_hid : onehot_to_id(prim_act);
        sel_hstate = sel_share ? pick_hstate : prim_act;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= SCHED_IDLE;
            issue_valid_reg  <= 1'b0;
            issue_hid_reg    <= '0;
            issue_hstate_reg <= '0;
            hart_switch_reg  <= 1'b0;
            rr_ptr_reg       <= '0;
            burst_cnt_reg    <= '0;
            had_issue_reg    <= 1'b0;
        end else if (bus.if_stall) begin
            hart_switch_reg <= 1'b0;
            // A held hart that went inactive (e.g. I-cache miss) must not stay on the bus
            if (issue_valid_reg && !bus.acti_hstate[issue_hid_reg]) begin
                issue_valid_reg  <= 1'b0;
                issue_hstate_reg <= '0;
                state_reg        <= SCHED_IDLE;
            end
        end else if (bus.acti_hstate == '0) begin
            state_reg        <= SCHED_IDLE;
            issue_valid_reg  <= 1'b0;
            issue_hstate_reg <= '0;
            hart_switch_reg  <= 1'b0;
        end else begin
            issue_valid_reg  <= 1'b1;
            issue_hid_reg    <= sel_hid;
            issue_hstate_reg <= sel_hstate;
            hart_switch_reg  <= had_issue_reg && (sel_hid != issue_hid_reg);
            had_issue_reg    <= 1'b1;
            if (sel_share) begin
                state_reg     <= SCHED_SHARE;
                rr_ptr_reg    <= pick_hid;
                burst_cnt_reg <= '0;
            end else begin
                state_reg     <= SCHED_PRIM;
                burst_cnt_reg <= (burst_cnt_reg == BURST_MAX) ? BURST_MAX
                                                               : burst_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.issue_valid  = issue_valid_reg;
    assign bus.issue_hid    = issue_hid_reg;
    assign bus.issue_hstate = issue_hstate_reg;
    assign bus.hart_switch  = hart_switch_reg;
    assign bus.sched_state  = state_reg;

    a_prim_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.prim_hstate));

endmodule

// File: tb/tb_hart_issue_sched.sv
// Bench for hart_issue_sched: directed scenarios then random traffic, with a
// queue-based scoreboard fed by an abstract reference model.
module tb_hart_issue_sched;
    import hart_issue_sched_pkg::*;

    logic clk;
    logic rst;

    hart_issue_sched_if bus ();

    hart_issue_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [1:0] hid;
        logic [3:0] hstate;
        logic       sw;
        logic [1:0] state;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_cycle  = 0;

    // Reference model state: what has been issued, not how the RTL encodes it
    logic       m_valid;
    int         m_hid;
    logic       m_sw;
    int         m_state;
    int         m_rr;
    int         m_burst;
    bit         m_had;
    int         m_last;

    function automatic int rr_pick(input logic [3:0] m, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            if (m[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic int first_set(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic model(input logic [3:0] a, input logic [3:0] p, input bit st, input bit r);
        int pick;
        if (r) begin
            m_valid = 0; m_hid = 0; m_sw = 0; m_state = 0;
            m_rr = 0; m_burst = 0; m_had = 0; m_last = 0;
        end else if (st) begin
            m_sw = 0;
            if (m_valid && !a[m_hid]) begin
                m_valid = 0; m_state = 0;
            end
        end else if (a == 4'b0000) begin
            m_valid = 0; m_sw = 0; m_state = 0;
        end else begin
            if ((p & a) == 4'b0000) begin
                pick = rr_pick(a, m_rr); m_rr = pick; m_burst = 0; m_state = 2;
            end else if ((a & ~p) == 4'b0000 || m_burst < PRIM_BURST) begin
                pick = first_set(p & a);
                m_burst = (m_burst + 1 > PRIM_BURST) ? PRIM_BURST : m_burst + 1;
                m_state = 1;
            end else begin
                pick = rr_pick(a & ~p, m_rr); m_rr = pick; m_burst = 0; m_state = 2;
            end
            m_sw = m_had && (pick != m_last);
            m_had = 1; m_last = pick; m_valid = 1; m_hid = pick;
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [3:0] p, input bit st, input bit r);
        exp_t e;
        @(negedge clk);
        rst             = r;
        bus.acti_hstate = a;
        bus.prim_hstate = p;
        bus.if_stall    = st;
        model(a, p, st, r);
        e.valid  = m_valid;
        e.hid    = 2'(m_hid);
        e.hstate = m_valid ? 4'(1 << m_hid) : 4'b0000;
        e.sw     = m_sw;
        e.state  = 2'(m_state);
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d required %0d", name, n_cycle, act, req);
    endtask

    // Monitor: every edge the DUT presents a fresh registered result
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cycle++;
                $display("cyc %0d valid=%0b hid=%0d hstate=%b switch=%0b state=%0d",
                         n_cycle, bus.issue_valid, bus.issue_hid, bus.issue_hstate,
                         bus.hart_switch, bus.sched_state);
                check("issue_valid",  int'(bus.issue_valid),  int'(e.valid));
                check("issue_hid",    int'(bus.issue_hid),    int'(e.hid));
                check("issue_hstate", int'(bus.issue_hstate), int'(e.hstate));
                check("hart_switch",  int'(bus.hart_switch),  int'(e.sw));
                check("sched_state",  int'(bus.sched_state),  int'(e.state));
            end
        end
    end

    initial begin
        logic [3:0] a, p;
        bit         st, r;
        rst = 1'b1;
        bus.acti_hstate = '0;
        bus.prim_hstate = '0;
        bus.if_stall    = 1'b0;

        step(4'b0000, 4'b0000, 0, 1);
        step(4'b0000, 4'b0000, 0, 1);
        repeat (5)  step(4'b0001, 4'b0001, 0, 0);
        repeat (8)  step(4'b0011, 4'b0001, 0, 0);
        repeat (16) step(4'b1111, 4'b0001, 0, 0);
        repeat (6)  step(4'b1010, 4'b0000, 0, 0);
        // Land on hart 2, hold it through a stall, then deactivate it while stalled
        step(4'b0100, 4'b0000, 0, 0);
        repeat (3)  step(4'b0100, 4'b0000, 1, 0);
        step(4'b0001, 4'b0001, 1, 0);
        step(4'b0001, 4'b0001, 1, 0);
        step(4'b0001, 4'b0001, 0, 0);
        repeat (3)  step(4'b0011, 4'b0001, 0, 0);
        step(4'b0000, 4'b0001, 0, 0);
        repeat (2)  step(4'b0011, 4'b0001, 0, 0);
        step(4'b0011, 4'b0001, 1, 1);
        step(4'b0011, 4'b0001, 0, 0);

        a = 4'b0011; p = 4'b0001;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                p = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
                a = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 2) != 0) a = a | p;
            end
            st = ($urandom_range(0, 4) == 0);
            r  = ($urandom_range(0, 99) == 0);
            step(a, p, st, r);
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
